// File: rtl/morse_pkg.sv
// Shared definitions for the Morse sequence renderer: tap encodings, FSM states,
// symbol record and Morse timing units.
package morse_pkg;

  localparam logic [1:0] TAP_SPACE = 2'd0;
  localparam logic [1:0] TAP_DASH  = 2'd1;
  localparam logic [1:0] TAP_DOT   = 2'd2;
  localparam logic [1:0] TAP_RSVD  = 2'd3;

  localparam int DOT_UNITS  = 1;
  localparam int DASH_UNITS = 3;
  localparam int GAP_UNITS  = 1;

  // Start columns are kept wide enough for any sensible SUPER_LEN*MAX_SYMS.
  localparam int START_W = 16;

  typedef enum logic [1:0] {EMPTY, ACCUM, HOLD} state_t;

  typedef struct packed {
    logic               is_dash;
    logic [START_W-1:0] start;
  } sym_t;

  function automatic int sym_units(input logic is_dash);
    return is_dash ? DASH_UNITS : DOT_UNITS;
  endfunction

endpackage

// File: rtl/morse_sym_buf.sv
// Symbol accumulation FSM: working buffer, cursor and overflow flag, plus the
// display shadow that is refreshed on every frame start.
module morse_sym_buf
  import morse_pkg::*;
#(
  parameter int SUPER_LEN = 5,
  parameter int MAX_SYMS  = 6
) (
  input  logic                               clk,
  input  logic                               rstb,
  input  logic                               frame_start,
  input  logic                               tap_valid,
  input  logic [1:0]                         tap,
  input  logic                               char_done,
  input  logic                               clear,
  output sym_t [MAX_SYMS-1:0]                shadow,
  output logic [$clog2(MAX_SYMS+1)-1:0]      shadow_count,
  output logic [$clog2(MAX_SYMS+1)-1:0]      sym_count,
  output logic                               full,
  output logic                               overflow
);

  localparam int CNT_W = $clog2(MAX_SYMS + 1);
  localparam int CUR_W = $clog2(4 * SUPER_LEN * MAX_SYMS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_SYMS);

  state_t                 state, state_n;
  logic [CNT_W-1:0]       count, count_n;
  logic [CUR_W-1:0]       cursor, cursor_n;
  sym_t [MAX_SYMS-1:0]    wbuf, wbuf_n;
  logic                   ovf, ovf_n;
  logic                   accepted;
  logic                   tap_dash;
  logic [CUR_W-1:0]       advance;

  assign accepted = tap_valid && (tap != TAP_SPACE) && (tap != TAP_RSVD);
  assign tap_dash = (tap == TAP_DASH);
  assign advance  = CUR_W'((sym_units(tap_dash) + GAP_UNITS) * SUPER_LEN);

  always_comb begin
    state_n  = state;
    count_n  = count;
    cursor_n = cursor;
    wbuf_n   = wbuf;
    ovf_n    = ovf;
    if (clear) begin
      state_n  = EMPTY;
      count_n  = '0;
      cursor_n = '0;
      ovf_n    = 1'b0;
    end else begin
      case (state)
        // EMPTY and HOLD both (re)start the buffer at index 0 on a tap
        EMPTY, HOLD: begin
          if (accepted) begin
            wbuf_n[0] = '{is_dash: tap_dash, start: '0};
            count_n   = CNT_W'(1);
            cursor_n  = advance;
            ovf_n     = 1'b0;
            state_n   = ACCUM;
          end
        end
        ACCUM: begin
          if (accepted) begin
            if (count != CNT_MAX) begin
              for (int i = 0; i < MAX_SYMS; i++) begin
                if (CNT_W'(i) == count) begin
                  wbuf_n[i] = '{is_dash: tap_dash, start: START_W'(cursor)};
                end
              end
              count_n  = count + CNT_W'(1);
              cursor_n = cursor + advance;
            end else begin
              ovf_n = 1'b1;
            end
          end
          if (char_done) begin
            state_n = HOLD;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  // The shadow takes the next-state buffer so a same-cycle tap or clear is included.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state        <= EMPTY;
      count        <= '0;
      cursor       <= '0;
      wbuf         <= '0;
      ovf          <= 1'b0;
      shadow       <= '0;
      shadow_count <= '0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      cursor <= cursor_n;
      wbuf   <= wbuf_n;
      ovf    <= ovf_n;
      if (frame_start) begin
        shadow       <= wbuf_n;
        shadow_count <= count_n;
      end
    end
  end

  assign sym_count = count;
  assign full      = (count == CNT_MAX);
  assign overflow  = ovf;

endmodule

// File: rtl/morse_seq_draw.sv
// Renders a buffered Morse symbol sequence as a row of bars inside a box,
// with a fixed two-cycle pixel pipeline from x/y to tft_v.
module morse_seq_draw
  import morse_pkg::*;
#(
  parameter int         SUPER_LEN = 5,
  parameter int         SYM_H     = 10,
  parameter int         MAX_SYMS  = 6,
  parameter logic [7:0] FG        = 8'd255,
  parameter logic [7:0] BG        = 8'd0
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic [9:0]                    box_x,
  input  logic [8:0]                    box_y,
  input  logic [9:0]                    x,
  input  logic [8:0]                    y,
  input  logic                          frame_start,
  input  logic                          tap_valid,
  input  logic [1:0]                    tap,
  input  logic                          char_done,
  input  logic                          clear,
  output logic [7:0]                    tft_v,
  output logic [$clog2(MAX_SYMS+1)-1:0] sym_count,
  output logic                          full,
  output logic                          overflow
);

  localparam int CNT_W = $clog2(MAX_SYMS + 1);
  localparam int CMP_W = START_W + 1;

  sym_t [MAX_SYMS-1:0] shadow;
  logic [CNT_W-1:0]    shadow_count;
  logic [9:0]          s1_rel_x;
  logic                s1_xin;
  logic                s1_yin;
  logic                s1_valid;
  logic [9:0]          y_end;
  logic [CMP_W-1:0]    rx;
  logic                hit;

  morse_sym_buf #(
    .SUPER_LEN (SUPER_LEN),
    .MAX_SYMS  (MAX_SYMS)
  ) u_buf (
    .clk          (clk),
    .rstb         (rstb),
    .frame_start  (frame_start),
    .tap_valid    (tap_valid),
    .tap          (tap),
    .char_done    (char_done),
    .clear        (clear),
    .shadow       (shadow),
    .shadow_count (shadow_count),
    .sym_count    (sym_count),
    .full         (full),
    .overflow     (overflow)
  );

  assign y_end = {1'b0, box_y} + 10'(SYM_H);
  assign rx    = CMP_W'(s1_rel_x);

  // Wide unsigned compares so bars running past the right edge never wrap.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < MAX_SYMS; i++) begin
      if ((CNT_W'(i) < shadow_count) &&
          (rx >= CMP_W'(shadow[i].start)) &&
          (rx <  CMP_W'(shadow[i].start) + CMP_W'(sym_units(shadow[i].is_dash) * SUPER_LEN))) begin
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      s1_rel_x <= '0;
      s1_xin   <= 1'b0;
      s1_yin   <= 1'b0;
      s1_valid <= 1'b0;
      tft_v    <= BG;
    end else begin
      s1_rel_x <= x - box_x;
      s1_xin   <= (x >= box_x);
      s1_yin   <= (y >= box_y) && ({1'b0, y} < y_end);
      s1_valid <= 1'b1;
      tft_v    <= (s1_valid && s1_xin && s1_yin && hit) ? FG : BG;
    end
  end

endmodule

// File: tb/tb_morse_seq_draw.sv
// Self-checking bench for morse_seq_draw: directed scenarios with literal
// expectations, then randomized traffic against a symbol-list reference model.
module tb_morse_seq_draw;

  localparam int         SUPER_LEN = 5;
  localparam int         SYM_H     = 10;
  localparam int         MAX_SYMS  = 6;
  localparam logic [7:0] FG        = 8'd255;
  localparam logic [7:0] BG        = 8'd0;
  localparam logic [1:0] T_DASH    = 2'd1;
  localparam logic [1:0] T_DOT     = 2'd2;

  logic       clk;
  logic       rstb;
  logic [9:0] box_x;
  logic [8:0] box_y;
  logic [9:0] x;
  logic [8:0] y;
  logic       frame_start;
  logic       tap_valid;
  logic [1:0] tap;
  logic       char_done;
  logic       clear;
  logic [7:0] tft_v;
  logic [2:0] sym_count;
  logic       full;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  morse_seq_draw #(
    .SUPER_LEN (SUPER_LEN),
    .SYM_H     (SYM_H),
    .MAX_SYMS  (MAX_SYMS),
    .FG        (FG),
    .BG        (BG)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .box_x       (box_x),
    .box_y       (box_y),
    .x           (x),
    .y           (y),
    .frame_start (frame_start),
    .tap_valid   (tap_valid),
    .tap         (tap),
    .char_done   (char_done),
    .clear       (clear),
    .tft_v       (tft_v),
    .sym_count   (sym_count),
    .full        (full),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the working buffer and shadow are plain lists of kinds (1 = dash).
  bit         mq[$];
  bit         sq[$];
  bit         m_hold = 1'b0;
  bit         m_ovf  = 1'b0;
  bit         m_valid = 1'b0;
  bit         acc, was_accum;
  logic [7:0] exp_tft = BG;
  int         s1x, s1y, s1bx, s1by;
  bit         s1v = 1'b0;

  // Bars laid out left to right: each symbol then one super-pixel gap.
  function automatic logic [7:0] model_pix(input int px, input int py, input int bx, input int by);
    int pos, len, rel;
    if (px < bx || py < by || py >= by + SYM_H) return BG;
    rel = px - bx;
    pos = 0;
    foreach (sq[i]) begin
      len = sq[i] ? 3 * SUPER_LEN : SUPER_LEN;
      if (rel >= pos && rel < pos + len) return FG;
      pos += len + SUPER_LEN;
    end
    return BG;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rstb) begin
      mq.delete();
      sq.delete();
      m_hold  = 1'b0;
      m_ovf   = 1'b0;
      s1v     = 1'b0;
      exp_tft = BG;
      m_valid = 1'b1;
    end else begin
      exp_tft = s1v ? model_pix(s1x, s1y, s1bx, s1by) : BG;
      s1x = int'(x); s1y = int'(y); s1bx = int'(box_x); s1by = int'(box_y);
      s1v = 1'b1;
      acc       = tap_valid && (tap == T_DASH || tap == T_DOT);
      was_accum = (mq.size() > 0) && !m_hold;
      if (clear) begin
        mq.delete();
        m_hold = 1'b0;
        m_ovf  = 1'b0;
      end else begin
        if (acc) begin
          if (m_hold) begin
            mq.delete();
            mq.push_back(tap == T_DASH);
            m_hold = 1'b0;
            m_ovf  = 1'b0;
          end else if (mq.size() < MAX_SYMS) begin
            mq.push_back(tap == T_DASH);
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (char_done && was_accum) m_hold = 1'b1;
      end
      if (frame_start) sq = mq;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("tft_v", 32'(tft_v), 32'(exp_tft));
      checkOutput("sym_count", 32'(sym_count), mq.size());
      checkOutput("full", 32'(full), 32'(mq.size() == MAX_SYMS));
      checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic applyStimulus(input logic fs, input logic tv, input logic [1:0] t,
                               input logic cd, input logic cl);
    frame_start = fs;
    tap_valid   = tv;
    tap         = t;
    char_done   = cd;
    clear       = cl;
    @(posedge clk); #1;
    frame_start = 1'b0;
    tap_valid   = 1'b0;
    tap         = 2'd0;
    char_done   = 1'b0;
    clear       = 1'b0;
  endtask

  task automatic probePixel(input string name, input int px, input int py, input logic [7:0] exp);
    x = 10'(px);
    y = 9'(py);
    repeat (2) @(posedge clk);
    #1;
    checkOutput(name, 32'(tft_v), 32'(exp));
  endtask

  task automatic scanRow(input int py, input int x0, input int x1);
    y = 9'(py);
    for (int i = x0; i <= x1; i++) begin
      x = 10'(i);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int tx, ty;
    rstb = 1'b0; box_x = 10'd100; box_y = 9'd120; x = '0; y = '0;
    frame_start = 1'b0; tap_valid = 1'b0; tap = 2'd0; char_done = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_tft", 32'(tft_v), 32'(BG));
    checkOutput("reset_count", 32'(sym_count), 0);
    checkOutput("reset_ovf", 32'(overflow), 0);
    rstb = 1'b1;

    // Dot then dash, latch, check bar columns and latency.
    applyStimulus(0, 1, T_DOT, 0, 0);
    applyStimulus(0, 1, T_DASH, 0, 0);
    applyStimulus(1, 0, 2'd0, 0, 0);
    checkOutput("model_pin_110", 32'(model_pix(110, 125, 100, 120)), 32'(FG));
    checkOutput("model_pin_105", 32'(model_pix(105, 125, 100, 120)), 32'(BG));
    x = 10'd200; y = 9'd125;
    repeat (3) @(posedge clk);
    #1; x = 10'd100;
    @(posedge clk); #1;
    checkOutput("latency_1cyc", 32'(tft_v), 32'(BG));
    @(posedge clk); #1;
    checkOutput("latency_2cyc", 32'(tft_v), 32'(FG));
    probePixel("px104", 104, 125, FG);
    probePixel("px105", 105, 125, BG);
    probePixel("px109", 109, 125, BG);
    probePixel("px110", 110, 125, FG);
    probePixel("px124", 124, 125, FG);
    probePixel("px125", 125, 125, BG);
    probePixel("left_of_box", 99, 125, BG);
    probePixel("below_band", 100, 130, BG);
    probePixel("top_row", 100, 120, FG);
    scanRow(125, 90, 140);

    // Fill to MAX_SYMS dots, then one dropped dash.
    applyStimulus(0, 0, 2'd0, 0, 1);
    for (int i = 0; i < MAX_SYMS; i++) applyStimulus(0, 1, T_DOT, 0, 0);
    applyStimulus(0, 1, T_DASH, 0, 0);
    checkOutput("full_count", 32'(sym_count), 6);
    checkOutput("full_flag", 32'(full), 1);
    checkOutput("ovf_flag", 32'(overflow), 1);
    applyStimulus(1, 0, 2'd0, 0, 0);
    probePixel("dot6", 150, 125, FG);
    probePixel("no_dash", 160, 125, BG);
    scanRow(124, 95, 180);

    // HOLD restart.
    applyStimulus(0, 0, 2'd0, 1, 0);
    applyStimulus(0, 1, T_DOT, 0, 0);
    checkOutput("hold_count", 32'(sym_count), 1);
    checkOutput("hold_ovf", 32'(overflow), 0);
    applyStimulus(1, 0, 2'd0, 0, 0);
    probePixel("hold_dot", 104, 125, FG);
    probePixel("hold_gone", 110, 125, BG);

    // Shadow only moves on frame_start, including a same-cycle tap.
    applyStimulus(1, 0, 2'd0, 0, 1);
    applyStimulus(0, 1, T_DOT, 0, 0);
    probePixel("no_latch", 100, 125, BG);
    applyStimulus(1, 1, T_DASH, 0, 0);
    probePixel("fs_with_tap", 110, 125, FG);
    checkOutput("fs_count", 32'(sym_count), 2);

    // Clear wins over tap and char_done.
    applyStimulus(0, 1, T_DOT, 1, 1);
    checkOutput("clear_count", 32'(sym_count), 0);
    applyStimulus(1, 0, 2'd0, 0, 0);
    probePixel("clear_bg", 100, 125, BG);

    // Ignored tap codes, and char_done ignored while EMPTY.
    applyStimulus(0, 1, 2'd0, 0, 0);
    applyStimulus(0, 1, 2'd3, 0, 0);
    checkOutput("ignored_empty", 32'(sym_count), 0);
    applyStimulus(0, 0, 2'd0, 1, 0);
    applyStimulus(0, 1, T_DOT, 0, 0);
    applyStimulus(0, 1, 2'd3, 0, 0);
    applyStimulus(0, 1, T_DOT, 0, 0);
    checkOutput("empty_char_done", 32'(sym_count), 2);

    // Randomized traffic with occasional box moves and mid-run resets.
    for (int c = 0; c < 4000; c++) begin
      if (c % 400 == 0) begin
        box_x = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(980, 1023)) : 10'($urandom_range(0, 1023));
        box_y = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(500, 511)) : 9'($urandom_range(0, 511));
      end
      rstb        = ($urandom_range(0, 299) != 0);
      tap_valid   = ($urandom_range(0, 99) < 30);
      tap         = 2'($urandom_range(0, 3));
      char_done   = ($urandom_range(0, 9) == 0);
      clear       = ($urandom_range(0, 49) == 0);
      frame_start = ($urandom_range(0, 19) == 0);
      tx = int'(box_x) + int'($urandom_range(0, 133)) - 3;
      ty = int'(box_y) + int'($urandom_range(0, 14)) - 2;
      x = 10'(tx & 1023);
      y = 9'(ty & 511);
      @(posedge clk); #1;
    end
    rstb = 1'b1;
    applyStimulus(0, 0, 2'd0, 0, 0);
    repeat (3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
